// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, parcel type and fetch FSM states
package cpu_pkg;

    localparam int          PARCEL_W      = 16;
    localparam int          FETCH_W       = 32;
    localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;

    typedef logic [PARCEL_W-1:0] parcel_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_q.sv
// rtl/fetch_q.sv - QD-entry parcel FIFO with one- or two-parcel push
module fetch_q
    import cpu_pkg::*;
#(
    parameter  int QD = 4,
    localparam int PW = $clog2(QD),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push1,
    input  logic          push2,
    input  parcel_t       din0,
    input  parcel_t       din1,
    input  logic          pop,
    output logic [CW-1:0] count,
    output parcel_t       head
);

    parcel_t         r_mem [QD];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_count;
    logic [1:0]      w_n_push;
    logic [PW-1:0]   w_wr_nxt;

    assign w_n_push = push2 ? 2'd2 : (push1 ? 2'd1 : 2'd0);
    assign w_wr_nxt = r_wr + PW'(1);
    assign count    = r_count;
    assign head     = r_mem[r_rd];

    // Pointers wrap naturally modulo QD; fullness is tracked by the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            r_wr    <= r_wr + PW'(w_n_push);
            r_rd    <= r_rd + PW'(pop);
            r_count <= r_count + CW'(w_n_push) - CW'(pop);
        end
    end

    // Parcel storage: din0 lands at the write pointer, din1 right after it
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push1 || push2) begin
                r_mem[r_wr] <= din0;
            end
            if (push2) begin
                r_mem[w_wr_nxt] <= din1;
            end
        end
    end

endmodule

// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch: word reads split into 16-bit parcels
module fetch
    import cpu_pkg::*;
#(
    parameter int            RV        = 32,
    parameter int            QD        = 4,
    parameter logic [RV-1:0] RESET_VEC = RESET_VEC_DEF[RV-1:0]
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall,
    input  logic          redirect,
    input  logic [RV-1:0] redirect_pc,
    output logic          mem_req,
    output logic [RV-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic [15:0]   ins,
    output logic          rdone,
    output logic [RV-1:0] ins_pc
);

    localparam int CW = $clog2(QD) + 1;

    fetch_state_t  r_state;
    logic [RV-1:0] r_fetch_pc;
    logic [RV-1:0] r_ins_pc;
    logic [RV-1:0] r_req_addr;

    logic [CW-1:0] w_count;
    parcel_t       w_head;
    parcel_t       w_din0;
    logic          w_space;
    logic          w_issue;
    logic          w_live;
    logic          w_ack_ok;
    logic          w_push1;
    logic          w_push2;
    logic [RV-1:0] w_redir_pc;
    logic [RV-1:0] w_word_addr;
    logic          w_unused_pc0;

    assign w_unused_pc0 = redirect_pc[0];
    assign w_redir_pc   = {redirect_pc[RV-1:1], 1'b0};
    assign w_word_addr  = {r_fetch_pc[RV-1:2], 2'b00};

    // Only one request is ever in flight, so nothing is reserved while idle
    assign w_space  = (CW'(QD) - w_count) >= CW'(2);
    assign w_issue  = (r_state == ST_IDLE) && !redirect && w_space && !reset;
    assign w_live   = w_issue || (r_state == ST_REQ);
    assign w_ack_ok = mem_ack && w_live && !redirect;
    assign w_push2  = w_ack_ok && !r_fetch_pc[1];
    assign w_push1  = w_ack_ok &&  r_fetch_pc[1];
    assign w_din0   = r_fetch_pc[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    assign mem_req  = w_issue || (r_state == ST_REQ) || (r_state == ST_DROP);
    assign mem_addr = (r_state == ST_IDLE) ? w_word_addr : r_req_addr;

    assign rdone    = (w_count != '0) && !stall && !redirect;
    assign ins      = w_head;
    assign ins_pc   = r_ins_pc;

    fetch_q #(
        .QD (QD)
    ) u_q (
        .clk   (clk),
        .reset (reset),
        .flush (redirect),
        .push1 (w_push1),
        .push2 (w_push2),
        .din0  (w_din0),
        .din1  (mem_rdata[31:16]),
        .pop   (rdone),
        .count (w_count),
        .head  (w_head)
    );

    // Request FSM: a zero-wait ack completes in IDLE; a redirect mid-request parks in DROP
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_req_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_issue && !mem_ack) begin
                        r_state    <= ST_REQ;
                        r_req_addr <= w_word_addr;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        r_state <= ST_IDLE;
                    end else if (redirect) begin
                        r_state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (mem_ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Fetch and delivery PCs; an odd-parcel fetch advances by 2 to realign
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_VEC;
            r_ins_pc   <= RESET_VEC;
        end else if (redirect) begin
            r_fetch_pc <= w_redir_pc;
            r_ins_pc   <= w_redir_pc;
        end else begin
            if (w_ack_ok) begin
                r_fetch_pc <= r_fetch_pc + (r_fetch_pc[1] ? RV'(2) : RV'(4));
            end
            if (rdone) begin
                r_ins_pc <= r_ins_pc + RV'(2);
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// tb/tb_fetch.sv - self-checking bench for fetch
`timescale 1ns/1ps
module tb_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [15:0] ins;
    logic        rdone;
    logic [31:0] ins_pc;

    logic        h_stall = 1'b0;
    logic        h_redirect = 1'b0;
    logic [15:0] h_redirect_pc = '0;
    logic        h_mem_req;
    logic [15:0] h_mem_addr;
    logic        h_mem_ack;
    logic [31:0] h_mem_rdata;
    logic [15:0] h_ins;
    logic        h_rdone;
    logic [15:0] h_ins_pc;

    int errors = 0;
    int checks = 0;
    int wait_n = 0;
    int wcnt;

    always #5 clk = ~clk;

    fetch #(.RV(32), .QD(4), .RESET_VEC(32'h0)) u_dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ins(ins), .rdone(rdone),
        .ins_pc(ins_pc)
    );

    fetch #(.RV(16), .QD(4), .RESET_VEC(16'h0)) u_dut16 (
        .clk(clk), .reset(reset), .stall(h_stall), .redirect(h_redirect),
        .redirect_pc(h_redirect_pc), .mem_req(h_mem_req), .mem_addr(h_mem_addr),
        .mem_ack(h_mem_ack), .mem_rdata(h_mem_rdata), .ins(h_ins), .rdone(h_rdone),
        .ins_pc(h_ins_pc)
    );

    // Instruction memory contents: a few fixed words, otherwise parcel = addr ^ 0x5A5A
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2222_1111;
            32'h0000_0004: return 32'h4444_3333;
            32'h0000_0100: return 32'hBBBB_AAAA;
            default:       return {a[15:0] ^ 16'h5A58, a[15:0] ^ 16'h5A5A};
        endcase
    endfunction

    function automatic logic [15:0] parcel(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word({a[31:2], 2'b00});
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // Memory with wait_n wait states; tolerates mem_req dropping without ack
    always_ff @(posedge clk) begin
        if (!mem_req || mem_ack) wcnt <= 0;
        else                     wcnt <= wcnt + 1;
    end

    always_comb begin
        mem_ack     = mem_req && (wcnt >= wait_n);
        mem_rdata   = mem_word(mem_addr);
        h_mem_ack   = h_mem_req;
        h_mem_rdata = mem_word({16'h0, h_mem_addr});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference stream: after reset/redirect to P, parcels at P, P+2, P+4, ... in order
    logic [31:0] exp_pc;
    logic        hold;
    logic [31:0] hold_addr;

    always @(negedge clk) begin
        if (reset) begin
            exp_pc = 32'h0;
            hold   = 1'b0;
        end else begin
            if (hold) begin
                check("req_held", {31'h0, mem_req}, 32'h1);
                check("addr_stable", mem_addr, hold_addr);
            end
            if (mem_req) check("addr_align", {30'h0, mem_addr[1:0]}, 32'h0);
            if (stall || redirect) check("rdone_gated", {31'h0, rdone}, 32'h0);
            if (rdone) begin
                check("sb_pc", ins_pc, exp_pc);
                check("sb_ins", {16'h0, ins}, {16'h0, parcel(exp_pc)});
                exp_pc = exp_pc + 32'd2;
            end
            if (redirect) exp_pc = {redirect_pc[31:1], 1'b0};
            hold      = mem_req && !mem_ack;
            hold_addr = mem_addr;
        end
    end

    typedef struct {
        logic        rst;
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_rdone;
        logic [15:0] exp_ins;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic st, input logic rq,
                                input logic [31:0] ad, input logic rd,
                                input logic [15:0] in, input logic [31:0] pc);
        vec_t v;
        v.rst = rst; v.stall = st; v.exp_req = rq; v.exp_addr = ad;
        v.exp_rdone = rd; v.exp_ins = in; v.exp_pc = pc;
        return v;
    endfunction

    task automatic apply_reset();
        reset = 1'b1; stall = 1'b0; redirect = 1'b0;
        h_stall = 1'b0; h_redirect = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bit got;
        int ndone;

        // Zero-wait fetch from reset, then stall-from-reset fill and release
        vecs.push_back(mk(1, 0, 1, 32'h0, 0, 16'h0,    32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h4, 1, 16'h1111, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0, 1, 16'h2222, 32'h2));
        vecs.push_back(mk(0, 0, 1, 32'h8, 1, 16'h3333, 32'h4));
        vecs.push_back(mk(0, 0, 0, 32'h0, 1, 16'h4444, 32'h6));
        vecs.push_back(mk(1, 1, 1, 32'h0, 0, 16'h0,    32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h4, 0, 16'h0,    32'h0));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 1, 0, 32'h0, 0, 16'h0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0, 1, 16'h1111, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0, 1, 16'h2222, 32'h2));
        vecs.push_back(mk(0, 0, 1, 32'h8, 1, 16'h3333, 32'h4));
        vecs.push_back(mk(0, 0, 0, 32'h0, 1, 16'h4444, 32'h6));

        wait_n = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) apply_reset();
            stall = vecs[i].stall;
            redirect = 1'b0;
            @(negedge clk);
            check($sformatf("vec%0d_req", i), {31'h0, mem_req}, {31'h0, vecs[i].exp_req});
            if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), mem_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_rdone", i), {31'h0, rdone}, {31'h0, vecs[i].exp_rdone});
            if (vecs[i].exp_rdone) begin
                check($sformatf("vec%0d_ins", i), {16'h0, ins}, {16'h0, vecs[i].exp_ins});
                check($sformatf("vec%0d_pc", i), ins_pc, vecs[i].exp_pc);
            end
            step();
        end

        // Redirect to an odd parcel while idle with a full queue
        apply_reset();
        stall = 1'b1;
        repeat (6) step();
        @(negedge clk);
        check("c_idle_req", {31'h0, mem_req}, 32'h0);
        step();
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        check("c_redir_rdone", {31'h0, rdone}, 32'h0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("c_req", {31'h0, mem_req}, 32'h1);
        check("c_addr", mem_addr, 32'h100);
        check("c_rdone0", {31'h0, rdone}, 32'h0);
        step();
        @(negedge clk);
        check("c_rdone1", {31'h0, rdone}, 32'h1);
        check("c_ins", {16'h0, ins}, 32'h0000_BBBB);
        check("c_pc", ins_pc, 32'h102);
        check("c_next_addr", mem_addr, 32'h104);
        step();

        // 3 wait states, redirect one cycle after the request rises
        wait_n = 3;
        apply_reset();
        @(negedge clk);
        check("d_req", {31'h0, mem_req}, 32'h1);
        check("d_ack", {31'h0, mem_ack}, 32'h0);
        step();
        redirect = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        check("d_redir_req", {31'h0, mem_req}, 32'h1);
        step();
        redirect = 1'b0;
        seen = 1'b0; got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            if (rdone) begin
                got = 1'b1;
                check("d_after_ack", {31'h0, seen}, 32'h1);
                check("d_pc", ins_pc, 32'h200);
                check("d_ins", {16'h0, ins}, {16'h0, parcel(32'h200)});
            end
            if (mem_ack && mem_addr == 32'h200) seen = 1'b1;
            step();
        end
        check("d_got", {31'h0, got}, 32'h1);

        // Redirect coinciding with an ack while the queue holds a parcel
        wait_n = 1;
        apply_reset();
        repeat (3) step();
        redirect = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        check("e_ack", {31'h0, mem_ack}, 32'h1);
        check("e_rdone", {31'h0, rdone}, 32'h0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check("e_empty", {31'h0, rdone}, 32'h0);
        check("e_req", {31'h0, mem_req}, 32'h1);
        check("e_addr", mem_addr, 32'h300);
        step();
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(negedge clk);
            if (rdone) begin
                got = 1'b1;
                check("e_pc", ins_pc, 32'h300);
                check("e_ins", {16'h0, ins}, {16'h0, parcel(32'h300)});
            end
            step();
        end
        check("e_got", {31'h0, got}, 32'h1);
        wait_n = 0;

        // 16-bit instance wrapping past 0xFFFC
        apply_reset();
        h_redirect = 1'b1; h_redirect_pc = 16'hFFFC;
        step();
        h_redirect = 1'b0;
        @(negedge clk);
        check("f_addr0", {16'h0, h_mem_addr}, 32'hFFFC);
        step();
        @(negedge clk);
        check("f_req1", {31'h0, h_mem_req}, 32'h1);
        check("f_addr1", {16'h0, h_mem_addr}, 32'h0000);
        for (int k = 0; k < 4; k++) begin
            logic [15:0] epc;
            epc = 16'hFFFC + 16'(2 * k);
            if (k > 0) begin
                step();
                @(negedge clk);
            end
            check($sformatf("f_rdone%0d", k), {31'h0, h_rdone}, 32'h1);
            check($sformatf("f_pc%0d", k), {16'h0, h_ins_pc}, {16'h0, epc});
            check($sformatf("f_ins%0d", k), {16'h0, h_ins}, {16'h0, parcel({16'h0, epc})});
        end
        step();

        // Random stall/redirect/wait-state traffic against the reference stream
        apply_reset();
        for (int c = 0; c < 3000; c++) begin
            reset       = ($urandom_range(0, 499) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = {20'h0, 12'($urandom)};
            if ($urandom_range(0, 31) == 0) wait_n = $urandom_range(0, 3);
            step();
        end
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; wait_n = 0;
        repeat (3) step();
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rdone) ndone++;
            step();
        end
        check("g_progress", {31'h0, ndone >= 30}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage directly upstream of the 16-bit compressed-ISA decoder.
- Issues 32-bit word reads on the instruction bus and splits each returned word into two 16-bit parcels.
- Parcels go into a small prefetch queue; the head is presented as ins/rdone, the valid strobe the decoder registers on.
- Handles branch/jump redirects by flushing the queue and discarding any in-flight read.

Parameters:
RV, 32, register/address width (16 or 32 legal)
QD, 4, prefetch queue depth in 16-bit parcels (power of 2, >=2)
RESET_VEC, 0, PC loaded at reset (bit 0 must be 0)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
stall  in  1  decoder/execute cannot accept a parcel this cycle
redirect  in  1  take new PC (branch/jump/trap)
redirect_pc  in  RV  new PC; bit 0 ignored (treated as 0)
mem_req  out  1  instruction read request
mem_addr  out  RV  word-aligned read address, bits[1:0]=0
mem_ack  in  1  read complete; mem_rdata valid this cycle
mem_rdata  in  32  fetched word; [15:0] = lower-address parcel
ins  out  16  parcel at queue head
rdone  out  1  ins valid and consumed this cycle
ins_pc  out  RV  address of the parcel on ins

Behaviour:
- Reset (async assert, sync release):
  - fetch_pc=RESET_VEC, ins_pc=RESET_VEC.
  - Queue empty, no request outstanding, drop flag clear.
  - mem_req=0, rdone=0.
  - ins and mem_addr are don't-care while their strobes are low.
- Request:
  - mem_req rises when no request is outstanding, redirect=0, and free slots minus parcels already reserved is >=2.
  - mem_addr={fetch_pc[RV-1:2],2'b00}.
  - mem_req stays high with a stable address until mem_ack; ack may arrive in the same cycle as req (zero-wait) or later.
  - At most one outstanding request.
- Response (mem_ack=1, not dropped):
  - fetch_pc[1]=0: push rdata[15:0] then rdata[31:16]; fetch_pc+=4.
  - fetch_pc[1]=1: push only rdata[31:16]; fetch_pc+=2, which realigns it.
  - The queue never overflows because space is reserved at request time.
- Output:
  - rdone = !empty & !stall & !redirect; this is combinational from registered queue state plus stall/redirect, with no path from mem_rdata.
  - ins = head parcel.
  - On rdone the head is popped and ins_pc+=2.
- Push and pop may both occur in the same cycle; the count updates net.
- Redirect (takes priority over everything else in that cycle):
  - Queue flushed and rdone=0.
  - fetch_pc and ins_pc load {redirect_pc[RV-1:1],1'b0}.
  - If a request is outstanding and not acked this cycle, drop flag set; the matching ack is consumed and its data discarded, and drop clears.
  - mem_req deasserts the cycle after that ack.
  - An ack arriving in the redirect cycle is discarded.
  - A new request may issue the cycle after redirect if nothing is outstanding.
- Latency with zero-wait memory: redirect in cycle N, mem_req/ack in N+1, first rdone in N+2, then one parcel per cycle sustained.
- Wrap-around:
  - fetch_pc and ins_pc wrap modulo 2^RV.
  - Queue pointers wrap modulo QD; full/empty use a count, not pointer equality.
- stall held high: queue fills to QD and requests cease; releasing stall resumes at the next unconsumed parcel, with none lost or duplicated.
- reset asserted mid-request: the outstanding request is forgotten. The memory model must tolerate mem_req dropping without ack.

Decomposition:
- Shared package (cpu_pkg) holds:
  - RESET_VEC default
  - PARCEL_W=16, FETCH_W=32
  - the parcel typedef
- One sub-module, fetch_q: parameterised QD-entry 16-bit FIFO.
  - push1/push2 (two-parcel write), pop, flush.
  - count, head outputs.
  - Async reset.
- fetch owns the request FSM, with states IDLE, REQ, DROP.

Test Plan:
- Reset, RESET_VEC=0, zero-wait memory returning 0x2222_1111 at 0, 0x4444_3333 at 4 -> mem_addr 0 then 4; rdone from cycle 2; ins 0x1111, 0x2222, 0x3333, 0x4444 with ins_pc 0, 2, 4, 6.
- stall=1 for 10 cycles after reset -> count reaches QD=4, mem_req low; release -> parcels 0x1111..0x4444 each exactly once, in order.
- redirect to 0x102 while idle, memory at 0x100 = 0xBBBB_AAAA -> mem_addr 0x100; only 0xBBBB delivered, ins_pc 0x102; next fetch at 0x104.
- 3-wait-state memory, redirect to 0x200 one cycle after mem_req -> old ack data discarded; no rdone until the 0x200 word returns; first ins_pc 0x200.
- redirect and mem_ack in the same cycle, with stall=0 and queue non-empty -> rdone=0 that cycle; queue empty next cycle; acked data not delivered.
- RV=16, fetch across 0xFFFC -> next mem_addr 0x0000, ins_pc wraps 0xFFFE to 0x0000.
